fir_da_mc: RTL and testbench

FIR_DA_MC -- requirements
Module: fir_da_mc

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_da_lut.sv | 23 ++
 rtl/fir_da_mc.sv | 154 +++++++++++++++
 tb/tb_fir_da_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel distributed-arithmetic FIR.
package fir_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_ROUND = 2'd2,
      S_HOLD  = 2'd3
   } fir_state_t;

   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   // Full-precision accumulator: one LUT entry scaled by up to 2^(DATA_W-1).
   function automatic int acc_width(input int lut_w, input int data_w);
      return lut_w + data_w;
   endfunction

   function automatic int cnt_width(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/fir_da_lut.sv
// Distributed-arithmetic coefficient LUT: synchronous write, combinational read.
module fir_da_lut #(
   parameter int TAPS  = 8,
   parameter int LUT_W = 23
) (
   input  logic             clk,
   input  logic             we,
   input  logic [TAPS-1:0]  waddr,
   input  logic [LUT_W-1:0] wdata,
   input  logic [TAPS-1:0]  raddr,
   output logic [LUT_W-1:0] rdata
);

   logic [LUT_W-1:0] mem [2**TAPS];

   // No reset: coefficients survive a datapath reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_da_mc.sv
// Bit-serial distributed-arithmetic FIR, time-multiplexed over CHANNELS delay lines
// sharing one coefficient LUT. One sample in flight: IDLE -> ACCUM -> ROUND -> HOLD.
module fir_da_mc
   import fir_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int TAPS      = 8,
   parameter int LUT_W     = 23,
   parameter int CHANNELS  = 2,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 0,
   localparam int CH_W     = ch_width(CHANNELS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic [CH_W-1:0]   din_ch,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic [LUT_W-1:0]  CIN,
   input  logic [TAPS-1:0]   CADDR,
   input  logic              CLOAD,
   output logic [OUT_W-1:0]  dout,
   output logic [CH_W-1:0]   dout_ch,
   output logic              valid_out,
   input  logic              ready_out,
   output logic              ch_err
);

   // Handshakes: a sample moves on a rising edge with valid_in & ready_in; a result
   // moves with valid_out & ready_out. valid_out holds, and dout/dout_ch stay put,
   // until the result is taken.

   localparam int ACC_W = acc_width(LUT_W, DATA_W);
   localparam int CNT_W = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CH_W:0]         CH_LIMIT = (CH_W + 1)'(CHANNELS);
   localparam logic signed [ACC_W:0] RND_BIAS = (OUT_SHIFT > 0) ?
      ((ACC_W + 1)'(1) << (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;

   fir_state_t state, state_next;

   logic signed [DATA_W-1:0] taps [CHANNELS][TAPS];
   logic [CH_W-1:0]          cur_ch;
   logic [CNT_W-1:0]         bit_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic [TAPS-1:0]          lut_addr;
   logic [LUT_W-1:0]         lut_data;
   logic signed [ACC_W-1:0]  lut_term;
   logic signed [ACC_W:0]    rounded;
   logic signed [ACC_W:0]    shifted;
   logic signed [OUT_W-1:0]  sat_out;
   logic                     ch_ok;
   logic                     accept;
   logic                     lut_we;

   assign ch_ok  = {1'b0, din_ch} < CH_LIMIT;
   assign accept = valid_in && ready_in;
   assign lut_we = CLOAD && (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready_in   = 1'b0;
      valid_out  = 1'b0;
      case (state)
         S_IDLE: begin
            ready_in = !CLOAD;
            if (!CLOAD && valid_in && ch_ok) state_next = S_ACCUM;
         end
         S_ACCUM: if (bit_cnt == LAST_BIT) state_next = S_ROUND;
         S_ROUND: state_next = S_HOLD;
         S_HOLD: begin
            valid_out = 1'b1;
            if (ready_out) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Address bit k is the current bit slice of tap k.
   always_comb begin
      lut_addr = '0;
      for (int k = 0; k < TAPS; k++) lut_addr[k] = taps[cur_ch][k][bit_cnt];
   end

   assign lut_term = {{DATA_W{lut_data[LUT_W-1]}}, lut_data} <<< bit_cnt;

   always_comb begin
      rounded = {acc[ACC_W-1], acc} + RND_BIAS;
      shifted = rounded >>> OUT_SHIFT;
      if (shifted > SAT_MAX)      sat_out = SAT_MAX[OUT_W-1:0];
      else if (shifted < SAT_MIN) sat_out = SAT_MIN[OUT_W-1:0];
      else                        sat_out = shifted[OUT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) taps[c][k] <= '0;
         cur_ch  <= '0;
         bit_cnt <= '0;
         acc     <= '0;
         ch_err  <= 1'b0;
         dout    <= '0;
         dout_ch <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (ch_ok) begin
                     for (int k = TAPS - 1; k > 0; k--) taps[din_ch][k] <= taps[din_ch][k-1];
                     taps[din_ch][0] <= din;
                     cur_ch  <= din_ch;
                     bit_cnt <= '0;
                     acc     <= '0;
                  end else begin
                     ch_err <= 1'b1;
                  end
               end
            end
            S_ACCUM: begin
               // The sign bit slice carries negative weight in two's complement.
               acc     <= (bit_cnt == LAST_BIT) ? acc - lut_term : acc + lut_term;
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            S_ROUND: begin
               dout    <= sat_out;
               dout_ch <= cur_ch;
            end
            default: ;
         endcase
      end
   end

   fir_da_lut #(
      .TAPS  (TAPS),
      .LUT_W (LUT_W)
   ) u_lut (
      .clk   (clk),
      .we    (lut_we),
      .waddr (CADDR),
      .wdata (CIN),
      .raddr (lut_addr),
      .rdata (lut_data)
   );

endmodule

// File: tb/tb_fir_da_mc.sv
// Directed + random bench for fir_da_mc: two instances run in lockstep (OUT_SHIFT 0 and 2,
// the second with a 2-bit channel field) against a direct-form FIR reference model.
module tb_fir_da_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] din;
   logic [1:0]  din_ch;
   logic        valid_in_a, valid_in_b;
   logic [22:0] CIN;
   logic [7:0]  CADDR;
   logic        CLOAD;
   logic        ready_out;

   logic        ready_in_a, valid_out_a, ch_err_a;
   logic [15:0] dout_a;
   logic [0:0]  dout_ch_a;
   logic        ready_in_b, valid_out_b, ch_err_b;
   logic [15:0] dout_b;
   logic [1:0]  dout_ch_b;

   int n_assert = 0;
   int n_fail   = 0;

   int          coef [8];
   int          line_m [2][8];
   logic [17:0] exp_a_q [$];
   logic [17:0] exp_b_q [$];

   fir_da_mc #(.DATA_W(16), .TAPS(8), .LUT_W(23), .CHANNELS(2), .OUT_W(16), .OUT_SHIFT(0)) u_dut_a (
      .clk(clk), .reset(reset), .din(din), .din_ch(din_ch[0]), .valid_in(valid_in_a),
      .ready_in(ready_in_a), .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD), .dout(dout_a),
      .dout_ch(dout_ch_a), .valid_out(valid_out_a), .ready_out(ready_out), .ch_err(ch_err_a)
   );

   fir_da_mc #(.DATA_W(16), .TAPS(8), .LUT_W(23), .CHANNELS(3), .OUT_W(16), .OUT_SHIFT(2)) u_dut_b (
      .clk(clk), .reset(reset), .din(din), .din_ch(din_ch), .valid_in(valid_in_b),
      .ready_in(ready_in_b), .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD), .dout(dout_b),
      .dout_ch(dout_ch_b), .valid_out(valid_out_b), .ready_out(ready_out), .ch_err(ch_err_b)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Direct-form reference: sum h[k]*x[k], round, arithmetic shift, saturate.
   function automatic logic [15:0] fir_model(input int ch, input int shift);
      longint acc;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(coef[k]) * longint'(line_m[ch][k]);
      if (shift > 0) acc += longint'(1) <<< (shift - 1);
      acc = acc >>> shift;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      return acc[15:0];
   endfunction

   task automatic clear_model();
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 8; k++) line_m[c][k] = 0;
      exp_a_q.delete();
      exp_b_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; valid_in_a = 1'b0; valid_in_b = 1'b0; CLOAD = 1'b0; ready_out = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_model();
      @(negedge clk);
      check("rst_ready_in_a", ready_in_a, 1);
      check("rst_ready_in_b", ready_in_b, 1);
      check("rst_valid_out_a", valid_out_a, 0);
      check("rst_valid_out_b", valid_out_b, 0);
      check("rst_dout_a", dout_a, 0);
      check("rst_dout_b", dout_b, 0);
      check("rst_dout_ch_a", dout_ch_a, 0);
      check("rst_dout_ch_b", dout_ch_b, 0);
      check("rst_ch_err_a", ch_err_a, 0);
      check("rst_ch_err_b", ch_err_b, 0);
   endtask

   // Writes LUT[a] = sum of h[k] over set bits of a, with a competing valid_in held high.
   task automatic load_lut(input int h [8]);
      int sum;
      coef = h;
      @(negedge clk);
      din = 16'h1111; din_ch = 2'd0; valid_in_a = 1'b1; valid_in_b = 1'b1; ready_out = 1'b0;
      for (int a = 0; a < 256; a++) begin
         sum = 0;
         for (int k = 0; k < 8; k++) if (a[k]) sum += h[k];
         CADDR = a[7:0];
         CIN   = sum[22:0];
         CLOAD = 1'b1;
         if (a == 0) begin
            #1;
            check("load_ready_in_a", ready_in_a, 0);
         end
         @(negedge clk);
      end
      CLOAD = 1'b0; valid_in_a = 1'b0; valid_in_b = 1'b0;
      @(negedge clk);
      check("cload_priority_a", valid_out_a, 0);
      check("cload_priority_b", valid_out_b, 0);
      check("load_done_ready_in", ready_in_a, 1);
      ready_out = 1'b1;
   endtask

   // Drives one sample into both instances, then waits for and scores the result.
   task automatic send(input int ch, input int data, input int stall);
      int n;
      logic [17:0] ea, eb;
      @(negedge clk);
      check("ready_in_idle", ready_in_a, 1);
      din = data[15:0]; din_ch = ch[1:0]; valid_in_a = 1'b1; valid_in_b = 1'b1;
      ready_out = (stall == 0);
      @(posedge clk);
      for (int k = 7; k > 0; k--) line_m[ch][k] = line_m[ch][k-1];
      line_m[ch][0] = data;
      exp_a_q.push_back({ch[1:0], fir_model(ch, 0)});
      exp_b_q.push_back({ch[1:0], fir_model(ch, 2)});
      n = 1;
      @(negedge clk);
      valid_in_a = 1'b0; valid_in_b = 1'b0;
      while (!valid_out_a && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, 18);
      check("valid_out_b", valid_out_b, 1);
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      check("dout_a", dout_a, ea[15:0]);
      check("dout_ch_a", dout_ch_a, ea[17:16]);
      check("dout_b", dout_b, eb[15:0]);
      check("dout_ch_b", dout_ch_b, eb[17:16]);
      for (int i = 0; i < stall; i++) begin
         check("hold_valid_out", valid_out_a, 1);
         check("hold_ready_in", ready_in_a, 0);
         check("hold_dout_a", dout_a, ea[15:0]);
         check("hold_dout_b", dout_b, eb[15:0]);
         @(negedge clk);
      end
      ready_out = 1'b1;
      @(negedge clk);
      check("valid_out_drop", valid_out_a, 0);
   endtask

   task automatic bad_channel();
      logic seen;
      @(negedge clk);
      din = 16'h0042; din_ch = 2'd3; valid_in_a = 1'b0; valid_in_b = 1'b1;
      #1;
      check("bad_ch_ready_in", ready_in_b, 1);
      @(negedge clk);
      valid_in_b = 1'b0;
      check("ch_err_b_set", ch_err_b, 1);
      check("ch_err_a_clear", ch_err_a, 0);
      check("bad_ch_stays_idle", ready_in_b, 1);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (valid_out_a || valid_out_b) seen = 1'b1;
      end
      check("bad_ch_no_valid_out", seen, 0);
   endtask

   task automatic reset_mid_accum();
      logic seen;
      @(negedge clk);
      din = 16'd77; din_ch = 2'd0; valid_in_a = 1'b1; valid_in_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_in_a = 1'b0; valid_in_b = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (valid_out_a || valid_out_b) seen = 1'b1;
      end
      check("abort_no_valid_out", seen, 0);
      check("abort_ready_in", ready_in_a, 1);
      check("abort_dout_a", dout_a, 0);
   endtask

   initial begin
      int hv [8];
      reset = 1'b1; din = '0; din_ch = '0; valid_in_a = 1'b0; valid_in_b = 1'b0;
      CIN = '0; CADDR = '0; CLOAD = 1'b0; ready_out = 1'b1;
      clear_model();

      do_reset();

      // Impulse-style identity filter
      hv = '{1, 0, 0, 0, 0, 0, 0, 0};
      load_lut(hv);
      send(0, 100, 0);
      send(0, 0, 0);
      send(0, 0, 0);

      // Saturation at both rails
      hv = '{4, 0, 0, 0, 0, 0, 0, 0};
      load_lut(hv);
      send(0, 32767, 0);
      send(0, -32768, 0);

      // Channel independence
      do_reset();
      hv = '{1, 1, 0, 0, 0, 0, 0, 0};
      load_lut(hv);
      send(0, 10, 0);
      send(1, 7, 0);
      send(0, 5, 0);

      // Rounding on the shifted instance, then a stalled output
      do_reset();
      hv = '{1, 0, 0, 0, 0, 0, 0, 0};
      load_lut(hv);
      send(0, 6, 0);
      send(0, -6, 0);
      send(1, 1234, 5);

      // Out-of-range channel
      bad_channel();
      send(0, 9, 0);
      check("ch_err_sticky", ch_err_b, 1);
      do_reset();

      // Reset during accumulation; LUT must survive
      hv = '{3, -2, 5, 1, 0, 0, 0, 7};
      load_lut(hv);
      send(0, 50, 0);
      send(1, -20, 0);
      reset_mid_accum();
      send(0, 1, 0);
      for (int i = 0; i < 7; i++) send(0, 0, 0);

      // Random coefficients, data, channels and stalls
      for (int k = 0; k < 8; k++) hv[k] = int'($urandom_range(0, 6)) - 3;
      load_lut(hv);
      for (int i = 0; i < 16; i++) begin
         send(int'($urandom_range(0, 1)), int'($urandom_range(0, 4000)) - 2000,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
